fphub_divider: RTL and testbench

Sequential HUB-format floating-point divider computing Z = X / Y over a start/done handshake. It is the inverse-direction companion to the combinational HUB multiplier and sits beside it in the FPHUB arithmetic unit. It uses identical operand packing, bias and truncation rules. Mantissas are divided by restoring iteration, one quotient bit per clock; special operands bypass the iteration.

---
 rtl/fphub_pkg.sv | 37 +++
 rtl/fphub_div_special.sv | 33 +++
 rtl/fphub_divider.sv | 127 ++++++++++++
 tb/tb_fphub_divider.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fphub_pkg.sv
// Shared definitions for the FPHUB divider: operand geometry, bias,
// FSM state encoding and special-pattern helpers.
package fphub_pkg;

    // Mantissa width (excluding implicit leading one and ILSB) and exponent width.
    localparam int M = 23;
    localparam int E = 8;
    localparam int W = E + M + 1;

    // HUB bias is 2^(E-1).
    localparam logic [E-1:0] BIAS = {1'b1, {(E-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Zero: exponent and mantissa fields all zeros (sign excluded).
    function automatic logic is_zero(input logic [W-2:0] mag);
        return (mag == '0);
    endfunction

    // Infinity: exponent and mantissa fields all ones (sign excluded).
    function automatic logic is_inf(input logic [W-2:0] mag);
        return (&mag);
    endfunction

    function automatic logic [W-1:0] make_inf(input logic sign);
        return {sign, {(W-1){1'b1}}};
    endfunction

    function automatic logic [W-1:0] make_zero(input logic sign);
        return {sign, {(W-1){1'b0}}};
    endfunction

endpackage

// File: rtl/fphub_div_special.sv
// Combinational operand classifier: flags operands that bypass the
// iteration and supplies the signed zero/infinity result for them.
module fphub_div_special
    import fphub_pkg::*;
(
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         special,
    output logic [W-1:0] result
);

    logic sign;
    logic x_zero;
    logic x_inf;
    logic y_zero;
    logic y_inf;

    // Classify both operands; divide-by-zero and infinite dividends win over zero results.
    always_comb begin
        sign    = x[W-1] ^ y[W-1];
        x_zero  = is_zero(x[W-2:0]);
        x_inf   = is_inf(x[W-2:0]);
        y_zero  = is_zero(y[W-2:0]);
        y_inf   = is_inf(y[W-2:0]);
        special = x_zero | x_inf | y_zero | y_inf;
        if (y_zero || x_inf) begin
            result = make_inf(sign);
        end else begin
            result = make_zero(sign);
        end
    end

endmodule

// File: rtl/fphub_divider.sv
// Sequential HUB floating-point divider Z = X / Y. Restoring division,
// one quotient bit per clock; special operands finish right after accept.
//
// Handshake: start is sampled only while idle (busy=0); the edge that sees
// start=1 in IDLE latches X and Y, after which they may change. start while
// busy is ignored. done pulses for exactly one cycle, and Z holds the result
// until the next result overwrites it.
module fphub_divider
    import fphub_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] X,
    input  logic [W-1:0] Y,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] Z
);

    localparam int CW = $clog2(M + 2);
    localparam logic [CW-1:0] LAST_STEP = CW'(M + 1);

    state_t         state;
    state_t         state_nx;
    logic [CW-1:0]  cnt;
    logic [M+2:0]   rem;
    logic [M+1:0]   sy;
    logic [M+1:0]   q;
    logic [E-1:0]   exp_base;
    logic           sign_r;

    logic           sp;
    logic [W-1:0]   sp_res;

    logic           ge;
    logic [M+2:0]   rem_sub;
    logic [M+2:0]   rem_nx;
    logic [M+1:0]   q_nx;
    logic [M-1:0]   mant_norm;
    logic [E-1:0]   exp_norm;

    fphub_div_special u_special (
        .x       (X),
        .y       (Y),
        .special (sp),
        .result  (sp_res)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_nx = state;
        busy     = (state != IDLE);
        done     = (state == DONE);
        case (state)
            IDLE: if (start) state_nx = sp ? DONE : DIV;
            DIV:  if (cnt == LAST_STEP) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // One restoring step plus normalisation of the quotient it completes.
    always_comb begin
        ge      = (rem >= {1'b0, sy});
        rem_sub = ge ? (rem - {1'b0, sy}) : rem;
        rem_nx  = rem_sub << 1;
        q_nx    = (q << 1) | {{(M+1){1'b0}}, ge};
        if (q_nx[M+1]) begin
            mant_norm = q_nx[M:1];
            exp_norm  = exp_base;
        end else begin
            mant_norm = q_nx[M-1:0];
            exp_norm  = exp_base - 1'b1;
        end
    end

    // Operand capture, iteration registers and result register.
    // Exponent arithmetic is done modulo 2^E; that equals keeping the low
    // E bits of an E+1-bit computation, so overflow/underflow simply wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            rem      <= '0;
            sy       <= '0;
            q        <= '0;
            exp_base <= '0;
            sign_r   <= 1'b0;
            Z        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rem      <= {1'b0, 1'b1, X[M-1:0], 1'b1};
                        sy       <= {1'b1, Y[M-1:0], 1'b1};
                        q        <= '0;
                        cnt      <= '0;
                        exp_base <= X[W-2:M] - Y[W-2:M] + BIAS;
                        sign_r   <= X[W-1] ^ Y[W-1];
                        if (sp) begin
                            Z <= sp_res;
                        end
                    end
                end
                DIV: begin
                    rem <= rem_nx;
                    q   <= q_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        Z <= {sign_r, exp_norm, mant_norm};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fphub_divider.sv
// Self-checking bench for fphub_divider (M=23, E=8).
module tb_fphub_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] X;
    logic [31:0] Y;
    logic        busy;
    logic        done;
    logic [31:0] Z;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    // Clock / reset block.
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    fphub_divider dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .X     (X),
        .Y     (Y),
        .busy  (busy),
        .done  (done),
        .Z     (Z)
    );

    // Reference: HUB division from the arithmetic definition.
    function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y);
        logic           s;
        longint unsigned sx;
        longint unsigned sy;
        longint unsigned q;
        int             e;
        logic [22:0]    mant;
        s = x[31] ^ y[31];
        if (y[30:0] == 31'd0 || x[30:0] == 31'h7FFFFFFF) return {s, 31'h7FFFFFFF};
        if (x[30:0] == 31'd0 || y[30:0] == 31'h7FFFFFFF) return {s, 31'd0};
        sx = 64'h100_0000 + 64'(x[22:0]) * 2 + 1;
        sy = 64'h100_0000 + 64'(y[22:0]) * 2 + 1;
        q  = (sx << 24) / sy;
        e  = int'(x[30:23]) - int'(y[30:23]) + 128;
        if (q >= 64'h100_0000) begin
            mant = 23'(q >> 1);
        end else begin
            mant = 23'(q);
            e    = e - 1;
        end
        return {s, 8'(e), mant};
    endfunction

    function automatic logic [31:0] rand_normal();
        logic [31:0] r;
        r = $urandom;
        while (r[30:0] == 31'd0 || r[30:0] == 31'h7FFFFFFF) r = $urandom;
        return r;
    endfunction

    // Driver: issue one operation, scramble inputs after accept, wait for done.
    // lat = edges after the accept edge at which done is first seen; -1 on timeout.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] z, output int lat);
        @(negedge clk);
        X = x; Y = y; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; X = $urandom; Y = $urandom;
        lat = 0;
        z = 'x;
        while (lat <= 60) begin
            if (done) begin
                z = Z;
                return;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; X = '0; Y = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_tests++;
        if (Z !== 32'h0) begin n_fail++; $display("FAIL reset_z: got %h want 00000000", Z); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int busy_bad;
        int done_cnt;
        int done_edge;
        logic [31:0] zc;
        busy_bad = 0; done_cnt = 0; done_edge = -1; zc = 'x;
        @(negedge clk);
        X = 32'h40000000; Y = 32'h40000000; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k <= 25 && busy !== 1'b1) busy_bad++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_edge < 0) begin done_edge = k; zc = Z; end
            end
        end
        n_tests++;
        if (done_edge != 25) begin n_fail++; $display("FAIL basic_latency: got %0d want 25", done_edge); end
        n_tests++;
        if (zc !== 32'h40000000) begin n_fail++; $display("FAIL basic_z: got %h want 40000000", zc); end
        n_tests++;
        if (busy_bad != 0) begin n_fail++; $display("FAIL basic_busy: %0d cycles low, want 0", busy_bad); end
        n_tests++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_pulse: got %0d cycles want 1", done_cnt); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: busy %b want 0", busy); end
    endtask

    task automatic test_sign();
        logic [31:0] z;
        int lat;
        run_op(32'h40800000, 32'h40000000, z, lat);
        n_tests++;
        if (z !== 32'h40800000 || lat != 25) begin
            n_fail++; $display("FAIL sign_pos: got %h lat %0d want 40800000 lat 25", z, lat);
        end
        run_op(32'hC0000000, 32'h40000000, z, lat);
        n_tests++;
        if (z !== 32'hC0000000 || lat != 25) begin
            n_fail++; $display("FAIL sign_neg: got %h lat %0d want C0000000 lat 25", z, lat);
        end
    endtask

    task automatic test_norm();
        logic [31:0] z;
        int lat;
        run_op(32'h40000000, 32'h407FFFFF, z, lat);
        n_tests++;
        if (z !== 32'h3F800000) begin n_fail++; $display("FAIL norm: got %h want 3F800000", z); end
    endtask

    task automatic test_special();
        logic [31:0] z;
        logic [31:0] xs;
        logic [31:0] ys;
        logic [31:0] sp_tab[4];
        int lat;
        sp_tab[0] = 32'h00000000; sp_tab[1] = 32'h80000000;
        sp_tab[2] = 32'h7FFFFFFF; sp_tab[3] = 32'hFFFFFFFF;
        run_op(32'h40000000, 32'h80000000, z, lat);
        n_tests++;
        if (z !== 32'hFFFFFFFF || lat != 0) begin
            n_fail++; $display("FAIL special_div0: got %h lat %0d want FFFFFFFF lat 0", z, lat);
        end
        run_op(32'h00000000, 32'h40000000, z, lat);
        n_tests++;
        if (z !== 32'h00000000 || lat != 0) begin
            n_fail++; $display("FAIL special_zero: got %h lat %0d want 00000000 lat 0", z, lat);
        end
        for (int i = 0; i < 16; i++) begin
            xs = ($urandom_range(0, 1) == 1) ? sp_tab[$urandom_range(0, 3)] : rand_normal();
            ys = sp_tab[i % 4];
            if (i >= 8) begin
                ys = xs; xs = sp_tab[i % 4];
            end
            run_op(xs, ys, z, lat);
            n_tests++;
            if (z !== ref_div(xs, ys) || lat != 0) begin
                n_fail++;
                $display("FAIL special_rand: %h/%h got %h lat %0d want %h lat 0", xs, ys, z, lat, ref_div(xs, ys));
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] xr;
        logic [31:0] yr;
        logic [31:0] z;
        logic [31:0] e;
        int lat;
        for (int i = 0; i < 500; i++) begin
            xr = rand_normal();
            yr = rand_normal();
            exp_q.push_back(ref_div(xr, yr));
            run_op(xr, yr, z, lat);
            e = exp_q.pop_front();
            n_tests++;
            if (z !== e || lat != 25) begin
                n_fail++; $display("FAIL random: %h/%h got %h lat %0d want %h lat 25", xr, yr, z, lat, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        int d1;
        int d2;
        logic [31:0] z1;
        logic [31:0] z2;
        logic b26;
        d1 = -1; d2 = -1; z1 = 'x; z2 = 'x; b26 = 1'bx;
        @(negedge clk);
        X = 32'h40800000; Y = 32'h40000000; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        X = 32'h41000000; Y = 32'h40000000;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 26) b26 = busy;
            if (k == 27) start = 1'b0;
            if (done === 1'b1) begin
                if (d1 < 0) begin d1 = k; z1 = Z; end
                else if (d2 < 0) begin d2 = k; z2 = Z; end
            end
        end
        n_tests++;
        if (z1 !== 32'h40800000 || d1 != 25) begin
            n_fail++; $display("FAIL b2b_first: got %h at %0d want 40800000 at 25", z1, d1);
        end
        n_tests++;
        if (b26 !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap: busy %b want 0", b26); end
        n_tests++;
        if (z2 !== 32'h41000000 || d2 != 52) begin
            n_fail++; $display("FAIL b2b_second: got %h at %0d want 41000000 at 52", z2, d2);
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        logic [31:0] z;
        int lat;
        stray = 0;
        @(negedge clk);
        X = 32'h40800000; Y = 32'h40000000; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || Z !== 32'h0) begin
            n_fail++; $display("FAIL reset_mid: busy %b done %b z %h want 0 0 00000000", busy, done, Z);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) stray++;
        end
        n_tests++;
        if (stray != 0) begin n_fail++; $display("FAIL reset_no_done: %0d active cycles want 0", stray); end
        run_op(32'h40000000, 32'h407FFFFF, z, lat);
        n_tests++;
        if (z !== 32'h3F800000 || lat != 25) begin
            n_fail++; $display("FAIL reset_recover: got %h lat %0d want 3F800000 lat 25", z, lat);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; X = '0; Y = '0;
        test_reset();
        test_basic();
        test_sign();
        test_norm();
        test_special();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
